// File: rtl/carfield_domain_ctrl.sv
// -----------------------------------------------------------------------------
// carfield_domain_ctrl
//
// Register-bus responder that owns the clock enables and synchronous resets of
// the gateable Carfield subdomains (periph, safety, security, integer cluster,
// FP cluster, L2). Software writes the requested on/off state per domain and a
// per-domain FSM sequences the change: clock enable before reset release on
// the way up, reset assertion before clock gating on the way down.
//
// Ports:
//   clk_i            sole clock
//   rst_i            synchronous, active-high reset
//   reg_req_i        narrow A32/D32 register request (addr, write, wdata, wstrb, valid)
//   reg_rsp_o        register response (rdata, error, ready)
//   domain_clk_en_o  clock-gate enable per domain
//   domain_rst_no    active-low domain reset per domain
//   busy_o           OR of all domains currently in a transient state
//
// Register map (offset = addr[4:2], only byte 0 / wstrb[0] is honoured):
//   0x00 DOMAIN_EN      RW  requested domain state
//   0x04 DOMAIN_STATUS  RO  domain is fully on
//   0x08 BUSY           RO  domain is in a transient state
//   0x0C RST_CYCLES     RW  reset dwell length used at each counter load
//   0x10 LOCK           RW  set-only, present only with CARFIELD_DOMAIN_CTRL_LOCK_EN
//
// Optional build macro: CARFIELD_DOMAIN_CTRL_LOCK_EN adds the LOCK register,
// which once set rejects writes to DOMAIN_EN and RST_CYCLES until rst_i.
//
// Per-domain FSM:
//   state       | meaning
//   ST_OFF      | clock gated, reset asserted
//   ST_CLK_ON   | clock running, reset held while the dwell counter drains
//   ST_ON       | clock running, reset released
//   ST_RST_ASSERT | reset asserted, clock kept running while the counter drains
// -----------------------------------------------------------------------------

package carfield_domain_ctrl_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } carfield_a32_d32_reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } carfield_a32_d32_reg_rsp_t;

endpackage

module carfield_domain_ctrl
    import carfield_domain_ctrl_pkg::*;
#(
    parameter int unsigned               NumDomains = 6,
    parameter logic [NumDomains-1:0]     DefaultOn  = NumDomains'(1),
    parameter int unsigned               CntWidth   = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  carfield_a32_d32_reg_req_t   reg_req_i,
    output carfield_a32_d32_reg_rsp_t   reg_rsp_o,
    output logic [NumDomains-1:0]       domain_clk_en_o,
    output logic [NumDomains-1:0]       domain_rst_no,
    output logic                        busy_o
);

    localparam logic [1:0] ST_OFF        = 2'd0;
    localparam logic [1:0] ST_CLK_ON     = 2'd1;
    localparam logic [1:0] ST_ON         = 2'd2;
    localparam logic [1:0] ST_RST_ASSERT = 2'd3;

    localparam logic [2:0] OFF_DOMAIN_EN = 3'd0;
    localparam logic [2:0] OFF_STATUS    = 3'd1;
    localparam logic [2:0] OFF_BUSY      = 3'd2;
    localparam logic [2:0] OFF_RST_CYC   = 3'd3;
`ifdef CARFIELD_DOMAIN_CTRL_LOCK_EN
    localparam logic [2:0] OFF_LOCK      = 3'd4;
`endif

    // ---------------------------------------------------------------------
    // Bus front end: capture the request on acceptance, answer one cycle later
    // ---------------------------------------------------------------------
    logic       req_pend_q;
    logic [2:0] req_off_q;
    logic       req_write_q;
    logic [7:0] req_wdata_q;
    logic       req_strb0_q;
    logic       req_accept;

    // Accepting only while no response is pending gives the 2-cycle cadence.
    assign req_accept = reg_req_i.valid && !req_pend_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_pend_q  <= 1'b0;
            req_off_q   <= '0;
            req_write_q <= 1'b0;
            req_wdata_q <= '0;
            req_strb0_q <= 1'b0;
        end else begin
            req_pend_q <= req_accept;
            if (req_accept) begin
                req_off_q   <= reg_req_i.addr[4:2];
                req_write_q <= reg_req_i.write;
                req_wdata_q <= reg_req_i.wdata[7:0];
                req_strb0_q <= reg_req_i.wstrb[0];
            end
        end
    end

    logic unused_req_bits;
    assign unused_req_bits = ^{reg_req_i.addr[31:5], reg_req_i.addr[1:0],
                               reg_req_i.wdata[31:8], reg_req_i.wstrb[3:1]};

    // ---------------------------------------------------------------------
    // Configuration registers
    // ---------------------------------------------------------------------
    logic [NumDomains-1:0] domain_en_q;
    logic [CntWidth-1:0]   rst_cycles_q;
    logic [NumDomains-1:0] status_on;
    logic [NumDomains-1:0] status_busy;
    logic                  locked;

    logic [31:0] rd_data;
    logic        rd_err;
    logic        wr_en_d;
    logic        wr_rc_d;
    logic        wr_lock_d;

    always_comb begin
        rd_data   = '0;
        rd_err    = 1'b0;
        wr_en_d   = 1'b0;
        wr_rc_d   = 1'b0;
        wr_lock_d = 1'b0;
        case (req_off_q)
            OFF_DOMAIN_EN: begin
                if (req_write_q) begin
                    if (locked)           rd_err  = 1'b1;
                    else if (req_strb0_q) wr_en_d = 1'b1;
                end else begin
                    rd_data[NumDomains-1:0] = domain_en_q;
                end
            end
            OFF_STATUS: begin
                if (req_write_q) rd_err = 1'b1;
                else             rd_data[NumDomains-1:0] = status_on;
            end
            OFF_BUSY: begin
                if (req_write_q) rd_err = 1'b1;
                else             rd_data[NumDomains-1:0] = status_busy;
            end
            OFF_RST_CYC: begin
                if (req_write_q) begin
                    if (locked)           rd_err  = 1'b1;
                    else if (req_strb0_q) wr_rc_d = 1'b1;
                end else begin
                    rd_data[CntWidth-1:0] = rst_cycles_q;
                end
            end
`ifdef CARFIELD_DOMAIN_CTRL_LOCK_EN
            OFF_LOCK: begin
                if (req_write_q) begin
                    // Set-only: a written 0 is silently ignored.
                    if (req_strb0_q && req_wdata_q[0]) wr_lock_d = 1'b1;
                end else begin
                    rd_data[0] = locked;
                end
            end
`endif
            default: rd_err = 1'b1;
        endcase
    end

    // Writes commit on the edge that closes the ready cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            domain_en_q  <= DefaultOn;
            rst_cycles_q <= CntWidth'(16);
        end else if (req_pend_q) begin
            if (wr_en_d) domain_en_q  <= req_wdata_q[NumDomains-1:0];
            if (wr_rc_d) rst_cycles_q <= req_wdata_q[CntWidth-1:0];
        end
    end

`ifdef CARFIELD_DOMAIN_CTRL_LOCK_EN
    logic lock_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q <= 1'b0;
        end else if (req_pend_q && wr_lock_d) begin
            lock_q <= 1'b1;
        end
    end

    assign locked = lock_q;
`else
    logic unused_lock;
    assign unused_lock = wr_lock_d;
    assign locked      = 1'b0;
`endif

    assign reg_rsp_o.ready = req_pend_q;
    assign reg_rsp_o.error = req_pend_q & rd_err;
    assign reg_rsp_o.rdata = req_pend_q ? rd_data : '0;

    // ---------------------------------------------------------------------
    // Per-domain sequencers with terminal-count down-counters
    // ---------------------------------------------------------------------
    logic [1:0]          state_q [NumDomains];
    logic [CntWidth-1:0] cnt_q   [NumDomains];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumDomains; i++) begin
                state_q[i] <= ST_OFF;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NumDomains; i++) begin
                case (state_q[i])
                    ST_OFF: begin
                        if (domain_en_q[i]) begin
                            state_q[i] <= ST_CLK_ON;
                            cnt_q[i]   <= rst_cycles_q;
                        end
                    end
                    ST_CLK_ON: begin
                        if (cnt_q[i] == '0) state_q[i] <= ST_ON;
                        else                cnt_q[i]   <= cnt_q[i] - CntWidth'(1);
                    end
                    ST_ON: begin
                        if (!domain_en_q[i]) begin
                            state_q[i] <= ST_RST_ASSERT;
                            cnt_q[i]   <= rst_cycles_q;
                        end
                    end
                    default: begin
                        if (cnt_q[i] == '0) state_q[i] <= ST_OFF;
                        else                cnt_q[i]   <= cnt_q[i] - CntWidth'(1);
                    end
                endcase
            end
        end
    end

    always_comb begin
        domain_clk_en_o = '0;
        domain_rst_no   = '0;
        status_on       = '0;
        status_busy     = '0;
        for (int i = 0; i < NumDomains; i++) begin
            domain_clk_en_o[i] = (state_q[i] != ST_OFF);
            domain_rst_no[i]   = (state_q[i] == ST_ON);
            status_on[i]       = (state_q[i] == ST_ON);
            status_busy[i]     = (state_q[i] == ST_CLK_ON) || (state_q[i] == ST_RST_ASSERT);
        end
    end

    assign busy_o = |status_busy;

endmodule

// File: tb/tb_carfield_domain_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for carfield_domain_ctrl. A reference model tracks each
// domain as a mode plus the absolute cycle at which its transient ends, and the
// register file as plain variables; every clock the DUT outputs are compared.
// -----------------------------------------------------------------------------

module tb_carfield_domain_ctrl;
    import carfield_domain_ctrl_pkg::*;

    localparam int ND = 6;

    logic                      clk_i = 1'b0;
    logic                      rst_i;
    carfield_a32_d32_reg_req_t reg_req_i;
    carfield_a32_d32_reg_rsp_t reg_rsp_o;
    logic [ND-1:0]             domain_clk_en_o;
    logic [ND-1:0]             domain_rst_no;
    logic                      busy_o;

    carfield_domain_ctrl dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .reg_req_i       (reg_req_i),
        .reg_rsp_o       (reg_rsp_o),
        .domain_clk_en_o (domain_clk_en_o),
        .domain_rst_no   (domain_rst_no),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 off, 1 powering up, 2 on, 3 powering down
    int          m_mode [ND];
    int          m_dead [ND];
    int          cyc = 0;
    logic [5:0]  m_en;
    logic [7:0]  m_rc;
    bit          m_lock;
    bit          exp_ready;
    bit          c_en, c_rc, c_lock;
    logic [7:0]  c_val;
    bit          saw_safety_on;

    function automatic logic [5:0] m_vec(input int which);
        logic [5:0] v;
        v = '0;
        for (int i = 0; i < ND; i++) begin
            case (which)
                0: v[i] = (m_mode[i] != 0);
                1: v[i] = (m_mode[i] == 2);
                default: v[i] = (m_mode[i] == 1) || (m_mode[i] == 3);
            endcase
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ND; i++) begin
            m_mode[i] = 0;
            m_dead[i] = 0;
        end
        m_en   = 6'b000001;
        m_rc   = 8'd16;
        m_lock = 1'b0;
        c_en = 0; c_rc = 0; c_lock = 0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        cyc++;
        if (rst_i) begin
            model_reset();
        end else begin
            for (int i = 0; i < ND; i++) begin
                case (m_mode[i])
                    0: if (m_en[i]) begin m_mode[i] = 1; m_dead[i] = cyc + int'(m_rc) + 1; end
                    1: if (cyc == m_dead[i]) m_mode[i] = 2;
                    2: if (!m_en[i]) begin m_mode[i] = 3; m_dead[i] = cyc + int'(m_rc) + 1; end
                    default: if (cyc == m_dead[i]) m_mode[i] = 0;
                endcase
            end
            if (c_en)   m_en   = c_val[5:0];
            if (c_rc)   m_rc   = c_val;
            if (c_lock) m_lock = 1'b1;
        end
        c_en = 0; c_rc = 0; c_lock = 0;
        #1;
        check_val("clk_en", 32'(domain_clk_en_o), 32'(m_vec(0)));
        check_val("rst_n",  32'(domain_rst_no),   32'(m_vec(1)));
        check_val("busy_o", 32'(busy_o),          32'(|m_vec(2)));
        check_val("gate_order", 32'(domain_rst_no & ~domain_clk_en_o), 32'd0);
        check_val("ready", 32'(reg_rsp_o.ready), 32'(exp_ready));
        if (!exp_ready) begin
            check_val("idle_rdata", reg_rsp_o.rdata, 32'd0);
            check_val("idle_error", 32'(reg_rsp_o.error), 32'd0);
        end
        if (domain_rst_no[1]) saw_safety_on = 1'b1;
    endtask

    // One complete access: returns #1 after the edge that commits a write.
    task automatic bus(input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                       input logic [3:0] strb, output logic [31:0] rd, output bit err);
        logic [31:0] e_rd;
        bit          e_err;
        reg_req_i.addr  = addr;
        reg_req_i.write = wr;
        reg_req_i.wdata = wd;
        reg_req_i.wstrb = strb;
        reg_req_i.valid = 1'b1;
        exp_ready = 1'b1;
        tick();
        reg_req_i.valid = 1'b0;
        rd  = reg_rsp_o.rdata;
        err = reg_rsp_o.error;
        e_rd  = '0;
        e_err = 1'b0;
        c_val = wd[7:0];
        case (addr[4:2])
            3'd0: if (wr) begin
                      if (m_lock) e_err = 1'b1; else c_en = strb[0];
                  end else e_rd = 32'(m_en);
            3'd1: if (wr) e_err = 1'b1; else e_rd = 32'(m_vec(1));
            3'd2: if (wr) e_err = 1'b1; else e_rd = 32'(m_vec(2));
            3'd3: if (wr) begin
                      if (m_lock) e_err = 1'b1; else c_rc = strb[0];
                  end else e_rd = 32'(m_rc);
`ifdef CARFIELD_DOMAIN_CTRL_LOCK_EN
            3'd4: if (wr) c_lock = strb[0] && wd[0]; else e_rd = 32'(m_lock);
`endif
            default: e_err = 1'b1;
        endcase
        check_val("rsp_rdata", rd, e_rd);
        check_val("rsp_error", 32'(err), 32'(e_err));
        exp_ready = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] rd;
        bit          err;
        int          n;

        reg_req_i = '0;
        exp_ready = 1'b0;
        saw_safety_on = 1'b0;
        model_reset();
        rst_i = 1'b1;
        repeat (3) tick();
        check_val("reset_clk_en", 32'(domain_clk_en_o), 32'd0);

        // Reset release: periph clock 1 cycle later, reset release 17 after that.
        rst_i = 1'b0;
        tick();
        check_val("periph_clk_en_rise", 32'(domain_clk_en_o), 32'h01);
        n = 0;
        while (!domain_rst_no[0] && n < 40) begin tick(); n++; end
        check_val("periph_dwell", n, 17);
        bus(32'h04, 0, 0, 4'hF, rd, err);
        check_val("status_after_boot", rd, 32'h01);
        bus(32'h0C, 0, 0, 4'hF, rd, err);
        check_val("rst_cycles_reset", rd, 32'd16);

        // Bring up FP cluster with 3 dwell cycles.
        bus(32'h0C, 1, 32'd3, 4'h1, rd, err);
        bus(32'h00, 1, 32'h11, 4'h1, rd, err);
        tick();
        check_val("fp_clk_en_rise", 32'(domain_clk_en_o[4]), 32'd1);
        n = busy_o ? 1 : 0;
        repeat (8) begin tick(); if (busy_o) n++; end
        check_val("fp_busy_cycles", n, 4);

        // Take FP cluster down.
        bus(32'h00, 1, 32'h01, 4'h1, rd, err);
        tick();
        check_val("fp_rst_drop", 32'(domain_rst_no[4]), 32'd0);
        check_val("fp_clk_held", 32'(domain_clk_en_o[4]), 32'd1);
        repeat (8) tick();
        check_val("fp_clk_off", 32'(domain_clk_en_o[4]), 32'd0);

        // Safety island toggled on and off inside its power-up transient.
        saw_safety_on = 1'b0;
        bus(32'h00, 1, 32'h03, 4'h1, rd, err);
        tick();
        bus(32'h00, 1, 32'h01, 4'h1, rd, err);
        repeat (15) tick();
        check_val("safety_reached_on", 32'(saw_safety_on), 32'd1);
        check_val("safety_back_off", 32'(domain_clk_en_o[1]), 32'd0);

        // Bus errors.
        bus(32'h18, 0, 0, 4'hF, rd, err);
        check_val("unmapped_err", 32'(err), 32'd1);
        bus(32'h04, 1, 32'h3F, 4'hF, rd, err);
        check_val("ro_write_err", 32'(err), 32'd1);
        bus(32'h00, 1, 32'h3F, 4'hE, rd, err);
        check_val("strb_write_err", 32'(err), 32'd0);
        bus(32'h00, 0, 0, 4'hF, rd, err);
        check_val("strb_no_effect", rd, 32'h01);

        // Randomised phase, including occasional mid-sequence resets.
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: bus(32'h00, 1, $urandom, 4'($urandom), rd, err);
                3:       bus(32'h0C, 1, 32'($urandom_range(0, 5)), 4'($urandom), rd, err);
                4, 5:    bus({27'($urandom), 3'($urandom), 2'($urandom)}, 0, 0, 4'hF, rd, err);
                6:       bus({27'd0, 3'($urandom_range(1, 7)), 2'd0}, 1, $urandom, 4'hF, rd, err);
                7, 8:    repeat ($urandom_range(1, 12)) tick();
                default: if ($urandom_range(0, 3) == 0) begin
                             rst_i = 1'b1;
                             tick();
                             rst_i = 1'b0;
                         end else tick();
            endcase
        end

`ifdef CARFIELD_DOMAIN_CTRL_LOCK_EN
        bus(32'h10, 1, 32'h1, 4'h1, rd, err);
        bus(32'h00, 1, 32'h3F, 4'h1, rd, err);
        check_val("locked_write_err", 32'(err), 32'd1);
        bus(32'h00, 0, 0, 4'hF, rd, err);
        check_val("locked_en_kept", rd, 32'(m_en));
`else
        bus(32'h00, 1, 32'h3F, 4'h1, rd, err);
`endif
        bus(32'h0C, 0, 0, 4'hF, rd, err);
        tick();
        rst_i = 1'b1;
        tick();
        check_val("reset_mid_clk_en", 32'(domain_clk_en_o), 32'd0);
        check_val("reset_mid_rst_n", 32'(domain_rst_no), 32'd0);
        rst_i = 1'b0;
        tick();
`ifdef CARFIELD_DOMAIN_CTRL_LOCK_EN
        bus(32'h10, 0, 0, 4'hF, rd, err);
        check_val("lock_cleared", rd, 32'd0);
`endif
        repeat (20) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/carfield_domain_ctrl.md
Name: carfield_domain_ctrl

Overview:
- Register-bus responder at the far end of the Carfield narrow A32/D32 register bus (`carfield_a32_d32_reg` request/response types).
- Owns clock enables and synchronous resets for the gateable subdomains: periph, safety island, security island, integer cluster, FP cluster and L2.
- Software requests a domain on or off. A per-domain FSM sequences the change: clock enable before reset release, and reset assertion before clock gating.
- Outputs feed the domain clock gates, the reset synchronisers and the `carfield_debug_sigs_t` debug port.

Parameters:
- NumDomains, 6, number of controlled domains; bit index equals `carfield_domains_e` value.
- DefaultOn, 6'b000001, reset value of DOMAIN_EN; periph domain comes up automatically after reset.
- CntWidth, 8, width of the reset-dwell counter and of the RST_CYCLES register.

Ports:
- clk_i  in  1  sole clock.
- rst_i  in  1  reset; synchronous, active-high.
- reg_req_i  in  `carfield_a32_d32_reg_req_t`  register request (addr, write, wdata, wstrb, valid).
- reg_rsp_o  out  `carfield_a32_d32_reg_rsp_t`  register response (rdata, error, ready).
- domain_clk_en_o  out  NumDomains  clock-gate enable per domain.
- domain_rst_no  out  NumDomains  active-low domain reset per domain.
- busy_o  out  1  OR of all domains currently in a transient state.

Behaviour:
Register map (offset addr[4:2]; addr[1:0] ignored; only wstrb[0] is honoured, and all fields sit in byte 0):
- 0x00 DOMAIN_EN: RW [NumDomains-1:0]; requested state; reset = DefaultOn.
- 0x04 DOMAIN_STATUS: RO; bit = 1 iff that domain is in ON.
- 0x08 BUSY: RO; bit = 1 iff that domain is in CLK_ON or RST_ASSERT.
- 0x0C RST_CYCLES: RW [CntWidth-1:0]; reset = 8'd16.
- Other offsets: error = 1, rdata = 0, no side effects.
- Writes with wstrb[0] = 0: no effect, no error. Writes to RO registers: error = 1, no effect. Unused rdata bits read 0.

Bus handshake:
- Request accepted when valid = 1 and the responder is idle.
- ready = 1 for exactly one cycle, the cycle after acceptance; rdata and error are valid in that cycle.
- Write data commits at the clock edge ending the ready cycle.
- Next request is accepted no earlier than the cycle after ready.
- Throughput: one access per 2 cycles.
- ready, error and rdata are 0 whenever no response is pending.

Per-domain FSM:
- States: OFF (clk_en 0, rst_n 0), CLK_ON (clk_en 1, rst_n 0), ON (clk_en 1, rst_n 1), RST_ASSERT (clk_en 0 is WRONG; clk_en 1, rst_n 0).
- OFF -> CLK_ON when the DOMAIN_EN bit is 1; counter loads RST_CYCLES.
- CLK_ON: counter decrements each cycle; -> ON on the cycle after the counter reads 0. Dwell = RST_CYCLES+1 cycles (1 cycle when RST_CYCLES = 0).
- ON -> RST_ASSERT when the DOMAIN_EN bit is 0; counter loads RST_CYCLES.
- RST_ASSERT: same countdown; -> OFF.
- DOMAIN_EN is sampled only in OFF and ON; changes during CLK_ON/RST_ASSERT take effect after the transient completes.
- A toggle on and back off within a transient completes the sequence, then reverses it.
- RST_CYCLES is sampled only at counter load; mid-sequence writes do not affect running counts.

Outputs and reset:
- domain_clk_en_o and domain_rst_no decode from the state flops only; there is no combinational path from reg_req_i.
- Under rst_i: all FSMs go to OFF, counters to 0, domain_clk_en_o = 0, domain_rst_no = 0, busy_o = 0, reg_rsp_o = 0, registers return to reset values.
- Reset asserted mid-sequence aborts the sequence immediately, with no ordering guarantee. Any pending bus response is dropped.
- After rst_i deasserts, DefaultOn domains start OFF -> CLK_ON on the first clock edge.

Optional Feature:
- Macro: `CARFIELD_DOMAIN_CTRL_LOCK_EN`.
- When defined: adds 0x10 LOCK, RW bit 0, set-only. Writing 1 sets it; writing 0 has no effect; cleared only by rst_i.
- While LOCK = 1, writes to DOMAIN_EN and RST_CYCLES return error = 1 and are discarded; reads are unaffected.
- When undefined: offset 0x10 is unmapped (error = 1) and there is no lock logic.

Test Plan:
- Reset release, default parameters:
  - periph clk_en rises 1 cycle after rst_i falls; its rst_n rises 17 cycles later.
  - DOMAIN_STATUS reads 0x01 once the sequence ends; all other domains stay 0/0.
- Write RST_CYCLES=3, then DOMAIN_EN=0x11 (adds FP cluster):
  - FP cluster clk_en rises 1 cycle after the write commits; rst_n rises 4 cycles later.
  - busy_o is high for exactly those 4 cycles.
- Write DOMAIN_EN=0x01 with FP cluster ON:
  - FP cluster rst_n drops 1 cycle after the commit; clk_en drops 4 cycles later.
  - clk_en never goes low while rst_n is high.
- Write DOMAIN_EN=0x03 and then 0x01 while safety island is in CLK_ON:
  - Safety island completes to ON (DOMAIN_STATUS bit1 = 1 for ≥1 cycle), then sequences back to OFF.
- Bus error checks:
  - Read offset 0x18 -> error = 1, rdata = 0.
  - Write 0x04 -> error = 1, no state change.
  - Write 0x00 with wstrb = 4'b1110 -> error = 0, DOMAIN_EN unchanged.
  - ready pulses exactly 1 cycle per access.
- With `CARFIELD_DOMAIN_CTRL_LOCK_EN` defined: write LOCK = 1, then DOMAIN_EN = 0x3F -> error = 1, DOMAIN_EN unchanged. Apply rst_i mid-CLK_ON -> all outputs 0 the next cycle and LOCK reads 0.
